// File: rtl/basic_rom_loader_pkg.sv
// Shared constants and FSM state type for the BASIC ROM-to-RAM boot loader.
package loader_pkg;

    localparam int unsigned BASIC_ROM_DEPTH = 4096;
    localparam logic [15:0] BASIC_RAM_BASE  = 16'hE000;
    localparam int unsigned ROM_ADDR_W      = 12;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        COPY,
        DONE
    } loader_state_e;

endpackage

// File: rtl/basic_rom_loader.sv
// Boot-time copier: streams the BASIC ROM into RAM, accumulates an 8-bit checksum
// and holds the CPU in reset until done. Optional checksum verify: LOADER_VERIFY_EN.
module basic_rom_loader
    import loader_pkg::*;
#(
    parameter int unsigned ROM_DEPTH    = BASIC_ROM_DEPTH,
    parameter logic [15:0] RAM_BASE     = BASIC_RAM_BASE,
    parameter int unsigned AUTO_START   = 1
`ifdef LOADER_VERIFY_EN
    ,
    parameter logic [7:0]  EXPECTED_SUM = 8'h00
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ROM_ADDR_W-1:0] rom_address,
    input  logic [7:0]            rom_dout,
    output logic [15:0]           ram_address,
    output logic [7:0]            ram_din,
    output logic                  ram_we,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_hold,
    output logic [7:0]            checksum
`ifdef LOADER_VERIFY_EN
    ,
    output logic                  verify_error
`endif
);

    localparam logic [ROM_ADDR_W-1:0] LAST_W = ROM_ADDR_W'(ROM_DEPTH - 1);

    loader_state_e         state_q, state_d;
    logic [ROM_ADDR_W-1:0] w_q, w_d;
    logic [7:0]            sum_q, sum_d;
    logic                  first_q, first_d;
    logic                  last_w;
    logic                  verr_q, verr_d;

    assign last_w = (w_q == LAST_W);

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        sum_d   = sum_q;
        first_d = 1'b0;
        verr_d  = verr_q;
        unique case (state_q)
            IDLE: begin
                // first_q marks the single cycle right after reset for auto-start
                if (start || ((AUTO_START != 0) && first_q)) begin
                    state_d = PRIME;
                    w_d     = '0;
                    sum_d   = '0;
                    verr_d  = 1'b0;
                end
            end
            PRIME: begin
                state_d = COPY;
                w_d     = '0;
                sum_d   = '0;
            end
            COPY: begin
                sum_d = sum_q + rom_dout;
                if (last_w) begin
                    state_d = DONE;
                    w_d     = '0;
`ifdef LOADER_VERIFY_EN
                    verr_d  = (sum_d != EXPECTED_SUM);
`endif
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = PRIME;
                    sum_d   = '0;
                    verr_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            w_q     <= '0;
            sum_q   <= '0;
            first_q <= 1'b1;
            verr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            sum_q   <= sum_d;
            first_q <= first_d;
            verr_q  <= verr_d;
        end
    end

    // ROM runs one address ahead of the write index to cover its read latency
    always_comb begin
        rom_address = '0;
        ram_din     = '0;
        if (state_q == COPY) begin
            rom_address = last_w ? w_q : (w_q + 1'b1);
            ram_din     = rom_dout;
        end
    end

    assign ram_address = RAM_BASE + 16'(w_q);
    assign ram_we      = (state_q == COPY);
    assign busy        = (state_q == PRIME) || (state_q == COPY);
    assign done        = (state_q == DONE);
    assign checksum    = sum_q;

`ifdef LOADER_VERIFY_EN
    assign verify_error = verr_q;
    assign cpu_hold     = !((state_q == DONE) && !verr_q);
`else
    assign cpu_hold     = (state_q != DONE);
`endif

endmodule
